// File: rtl/ifu_pcgen.sv
// Fetch-side PC generator.
// Keeps the architectural fetch PC, issues one instruction-memory read at a
// time, and hands each returned word to decode together with its PC. A
// resolved redirect from the branch unit squashes the wrong-path fetch and
// restarts fetching at the target.
module ifu_pcgen #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] STEP     = 32'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  // redirect from the branch unit
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  // instruction-memory request channel
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  // instruction-memory response
  input  logic        rsp_valid,
  input  logic [31:0] rsp_data,
  // decode channel
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [31:0] pc;
  logic [31:0] fly_pc;
  logic        drop;

  logic        req_hs;
  logic        inst_hs;
  logic        rsp_take;
  logic        rsp_keep;
  logic [31:0] redir_pc;

  // Redirect targets are word addresses; the low two bits carry no meaning.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  // Sequential fetch increment; wraps naturally at 2^32.
  function automatic logic [31:0] pc_step(input logic [31:0] addr);
    return addr + STEP;
  endfunction

  assign req_hs   = req_valid & req_ready;
  assign inst_hs  = inst_valid & inst_ready;
  // A response is only meaningful while a request is outstanding.
  assign rsp_take = (state == S_WAIT) & rsp_valid;
  // The response reaches decode only if it is on the right path: no pending
  // squash and no redirect arriving in the same cycle.
  assign rsp_keep = rsp_take & ~drop & ~redirect_valid;
  assign redir_pc = word_align(redirect_target);

  // State register; reset drops both valids immediately via the output decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a redirect only matters where it forces a restart.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        state_nxt = S_REQ;
      end
      S_REQ: begin
        // Even a wrong-path handshake still has a response to collect.
        if (req_hs) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (rsp_take) begin
          state_nxt = rsp_keep ? S_OUT : S_REQ;
        end
      end
      S_OUT: begin
        if (redirect_valid || inst_hs) begin
          state_nxt = S_REQ;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Output decode from the current state.
  always_comb begin
    req_valid  = 1'b0;
    inst_valid = 1'b0;
    case (state)
      S_REQ:   req_valid  = 1'b1;
      S_OUT:   inst_valid = 1'b1;
      default: begin
        req_valid  = 1'b0;
        inst_valid = 1'b0;
      end
    endcase
  end

  assign req_addr = pc;

  // Fetch PC: a redirect overrides the sequential increment on a handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= redir_pc;
    end else if (req_hs) begin
      pc <= pc_step(pc);
    end
  end

  // PC of the outstanding request; only read when its response is kept.
  always_ff @(posedge clk) begin
    if (req_hs) begin
      fly_pc <= pc;
    end
  end

  // Squash flag: marks the single outstanding response as wrong-path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop <= 1'b0;
    end else if (rsp_take) begin
      // Whatever arrives now is consumed, kept or not; nothing remains in flight.
      drop <= 1'b0;
    end else if (redirect_valid && (req_hs || state == S_WAIT)) begin
      drop <= 1'b1;
    end
  end

  // Decode holding registers; stay stable while decode back-pressures.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst    <= 32'd0;
      inst_pc <= 32'd0;
    end else if (rsp_keep) begin
      inst    <= rsp_data;
      inst_pc <= fly_pc;
    end
  end

endmodule

// File: doc/ifu_pcgen.md
Name: ifu_pcgen

Overview:
- Fetch-side PC generator. It is the consumer of the branch unit's resolved redirect (`taken` qualified into `redirect_valid`, plus `target`).
- Holds the architectural fetch PC and issues one instruction-memory read at a time over a valid/ready request channel.
- Accepts the response and presents the instruction plus its PC to decode over a valid/ready output channel.
- On redirect, squashes the wrong-path fetch and restarts at the target.

Parameters:
- RESET_PC, 32'h8000_0000, first fetch address after reset.
- STEP, 4, PC increment for sequential fetch.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- redirect_valid  input  1  branch unit resolved a taken jump/branch this cycle.
- redirect_target  input  32  new fetch address. Bits [1:0] are ignored and treated as 0.
- req_valid  output  1  memory read request valid.
- req_ready  input  1  memory accepts request.
- req_addr  output  32  word address being fetched.
- rsp_valid  input  1  read data valid. Exactly one response per accepted request, at least 1 cycle after the handshake.
- rsp_data  input  32  instruction word.
- inst_valid  output  1  instruction available to decode.
- inst_ready  input  1  decode accepts instruction.
- inst  output  32  instruction word.
- inst_pc  output  32  PC of `inst`.

Behaviour:
- Registers:
  - `pc`: next address to request.
  - `fly_pc`: PC of the outstanding request.
  - `drop`: discard the outstanding response.
  - `inst`/`inst_pc`: output holding registers.
  - `state`.
- FSM states: IDLE, REQ, WAIT, OUT.
- Reset (async, `rst_n`=0):
  - state=IDLE, pc=RESET_PC, drop=0.
  - req_valid=0, inst_valid=0, inst=0, inst_pc=0.
- Output decode:
  - req_valid=1 only in REQ.
  - req_addr=pc.
  - inst_valid=1 only in OUT.
- IDLE: unconditionally -> REQ next cycle. The first request appears on the 1st edge after `rst_n` rises.
- REQ, on handshake (req_valid & req_ready):
  - fly_pc<=pc, pc<=pc+STEP (mod 2^32, wraps 0xFFFF_FFFC -> 0x0000_0000), -> WAIT.
  - Without a handshake, stay in REQ.
- WAIT, on rsp_valid:
  - If drop=1: discard the data, drop<=0, -> REQ.
  - Else: inst<=rsp_data, inst_pc<=fly_pc, -> OUT.
- OUT, on handshake (inst_valid & inst_ready): -> REQ. Otherwise hold inst/inst_pc stable.
- Redirect (redirect_valid=1) has priority over every sequential update. pc<={redirect_target[31:2],2'b00} in all states. Per-state effect:
  - IDLE: pc updated, still -> REQ.
  - REQ, no handshake: stay REQ. req_addr shows the target next cycle. The memory samples address only on handshake, so the address change while valid is legal only in this case.
  - REQ with handshake in the same cycle: the request went out on the wrong path -> WAIT with drop<=1. fly_pc is irrelevant. pc=target, not target+STEP.
  - WAIT, no rsp_valid: drop<=1, stay WAIT.
  - WAIT with rsp_valid in the same cycle: data discarded, drop<=0, -> REQ.
  - OUT: inst_valid drops next cycle, -> REQ. If inst_ready was high in the same cycle, the transfer counts as done and decode is responsible for flushing it on redirect.
- A second redirect while drop=1 only overwrites pc. Still exactly one response is discarded.
- Outstanding requests never exceed 1. req_valid is never high in WAIT or OUT.
- Throughput: at best one instruction per 3 cycles (REQ -> WAIT -> OUT) with 1-cycle memory and always-ready decode.
- Reset asserted mid-operation returns to IDLE immediately. A response arriving after reset release while in IDLE or REQ is ignored; memory must also be reset.

Test Plan:
- Reset release, req_ready=1, 1-cycle rsp of 0x00000013, inst_ready=1 -> req_addr 0x80000000, 0x80000004, 0x80000008. inst_pc follows the same sequence. inst=0x00000013. No inst_valid before the first rsp.
- Decode back-pressure: inst_ready=0 for 5 cycles in OUT -> inst/inst_pc stable, req_valid=0 throughout. Release -> next req_addr = inst_pc+4.
- Redirect in WAIT: request 0x80000008 outstanding, redirect_target=0x80000100, rsp arrives 3 cycles later -> that rsp never reaches inst_valid. Next req_addr=0x80000100.
- Redirect coincident with REQ handshake (target 0x80000203) -> one response dropped. Next req_addr=0x80000200, never 0x80000204.
- Redirect in OUT with inst_ready=0 and req_ready stalled for 2 cycles -> inst_valid low the next cycle. req_addr=target held while req_valid=1 until handshake.
- Wrap and async reset: pc=0xFFFFFFFC fetch -> next req_addr 0x00000000. Assert rst_n=0 mid-WAIT -> req_valid/inst_valid=0 immediately. After release, restart at 0x80000000.
